dly_coarse_cal: RTL

DLY_COARSE_CAL -- requirements
Module: dly_coarse_cal

---
 rtl/dly_coarse_cal.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/dly_coarse_cal.sv
// Calibration sweep controller for a 4-step coarse delay cell: walks o_sel 0..3 until the phase detector reports late.
// Optional majority-vote sampling (4 samples, >=3 ones) enabled by defining DLY_CAL_AVG_EN.
module dly_coarse_cal #(
  parameter int unsigned SETTLE_CYC = 4
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_start,
  input  logic       i_pd,
  output logic [1:0] o_sel,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_lock,
  output logic       o_err
);

  typedef enum logic [2:0] {IDLE, SETTLE, SAMPLE, EVAL, DONE} state_e;

  state_e     state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       lock_q, lock_d;
  logic       err_q, err_d;
  logic [3:0] settle_cnt_q, settle_cnt_d;
  logic       result;

`ifdef DLY_CAL_AVG_EN
  logic [1:0] samp_cnt_q, samp_cnt_d;
  logic [2:0] vote_q, vote_d;
  assign result = (vote_q >= 3'd3);
`else
  logic pd_q, pd_d;
  assign result = pd_q;
`endif

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    lock_d       = lock_q;
    err_d        = err_q;
    settle_cnt_d = settle_cnt_q;
`ifdef DLY_CAL_AVG_EN
    samp_cnt_d   = samp_cnt_q;
    vote_d       = vote_q;
`else
    pd_d         = pd_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d      = SETTLE;
          sel_d        = 2'd0;
          busy_d       = 1'b1;
          lock_d       = 1'b0;
          err_d        = 1'b0;
          settle_cnt_d = 4'(SETTLE_CYC);
`ifdef DLY_CAL_AVG_EN
          samp_cnt_d   = '0;
          vote_d       = '0;
`endif
        end
      end
      SETTLE: begin
        if (settle_cnt_q <= 4'd1) begin
          settle_cnt_d = '0;
          state_d      = SAMPLE;
        end else begin
          settle_cnt_d = settle_cnt_q - 4'd1;
        end
      end
      SAMPLE: begin
`ifdef DLY_CAL_AVG_EN
        // sample counter wraps back to 0 on the fourth sample
        vote_d     = vote_q + 3'(i_pd);
        samp_cnt_d = samp_cnt_q + 2'd1;
        if (samp_cnt_q == 2'd3) state_d = EVAL;
`else
        pd_d    = i_pd;
        state_d = EVAL;
`endif
      end
      EVAL: begin
        if (result) begin
          lock_d  = 1'b1;
          state_d = DONE;
        end else if (sel_q == 2'd3) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          sel_d        = sel_q + 2'd1;
          settle_cnt_d = 4'(SETTLE_CYC);
`ifdef DLY_CAL_AVG_EN
          vote_d       = '0;
`endif
          state_d      = SETTLE;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      lock_q       <= 1'b0;
      err_q        <= 1'b0;
      settle_cnt_q <= '0;
`ifdef DLY_CAL_AVG_EN
      samp_cnt_q   <= '0;
      vote_q       <= '0;
`else
      pd_q         <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      lock_q       <= lock_d;
      err_q        <= err_d;
      settle_cnt_q <= settle_cnt_d;
`ifdef DLY_CAL_AVG_EN
      samp_cnt_q   <= samp_cnt_d;
      vote_q       <= vote_d;
`else
      pd_q         <= pd_d;
`endif
    end
  end

  assign o_sel  = sel_q;
  assign o_busy = busy_q;
  assign o_done = done_q;
  assign o_lock = lock_q;
  assign o_err  = err_q;

endmodule
